// File: rtl/somador_pkg.sv
// Shared types for the somador_acumulador block: operation codes and control states.
package somador_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/somador_acumulador_if.sv
// Operation request / accumulator result bundle between operand sources and the accumulator.
interface somador_acumulador_if #(
  parameter int WIDTH = 8
);
  import somador_pkg::*;

  logic                    in_valid;
  op_t                     op;
  logic signed [WIDTH-1:0] B;
  logic signed [WIDTH-1:0] S;
  logic                    out_valid;
  logic                    Z;
  logic                    N;
  logic                    P;
  logic                    V;
  logic                    V_sticky;

  modport master (
    output in_valid, op, B,
    input  S, out_valid, Z, N, P, V, V_sticky
  );

  modport slave (
    input  in_valid, op, B,
    output S, out_valid, Z, N, P, V, V_sticky
  );

endinterface

// File: rtl/somador_flags.sv
// Zero / negative / even flags of a signed value; purely combinational, shared with ALU blocks.
module somador_flags #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] S,
  output logic                    Z,
  output logic                    N,
  output logic                    P
);

  assign Z = (S == '0);
  assign N = S[WIDTH-1];
  assign P = ~S[0];

endmodule

// File: rtl/somador_acumulador.sv
// Clocked signed accumulator (LOAD/ADD/SUB/CLR) with Z/N/P, overflow and sticky-overflow flags.
// Define SOMADOR_SATURATE_EN to clamp S on overflow instead of wrapping.
module somador_acumulador
  import somador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  somador_acumulador_if.slave bus
);

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] acc_p0;
  logic                    v_p0;
  logic                    vs_p0;

  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   b_ext;
  logic signed [WIDTH:0]   res;
  logic                    ovf;
  logic signed [WIDTH-1:0] acc_nxt;

`ifdef SOMADOR_SATURATE_EN
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH:0] r);
    logic signed [WIDTH-1:0] lim;
    lim = r[WIDTH-1:0];
    if (r[WIDTH] != r[WIDTH-1]) begin
      // The extra bit carries the true sign: negative overflow clamps low, positive clamps high.
      lim = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return lim;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RESULT;
      RESULT:  if (bus.in_valid) state_nxt = RESULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_ext = {acc_p0[WIDTH-1], acc_p0};
  assign b_ext = {bus.B[WIDTH-1], bus.B};
  assign res   = (bus.op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  // A sign-extended sum whose top two bits disagree is exactly the same-sign-in, flipped-sign-out case.
  assign ovf   = (res[WIDTH] != res[WIDTH-1]);

`ifdef SOMADOR_SATURATE_EN
  assign acc_nxt = saturate(res);
`else
  assign acc_nxt = res[WIDTH-1:0];
`endif

  // Result stage: accumulator and overflow flags update on each accepted op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      v_p0   <= 1'b0;
      vs_p0  <= 1'b0;
    end else if (bus.in_valid) begin
      case (bus.op)
        OP_LOAD: begin
          acc_p0 <= bus.B;
          v_p0   <= 1'b0;
        end
        OP_ADD, OP_SUB: begin
          acc_p0 <= acc_nxt;
          v_p0   <= ovf;
          if (ovf) vs_p0 <= 1'b1;
        end
        OP_CLR: begin
          acc_p0 <= '0;
          v_p0   <= 1'b0;
          vs_p0  <= 1'b0;
        end
        default: begin
          acc_p0 <= acc_p0;
        end
      endcase
    end
  end

  assign bus.S         = acc_p0;
  assign bus.V         = v_p0;
  assign bus.V_sticky  = vs_p0;
  assign bus.out_valid = (state == RESULT);

  somador_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .S(acc_p0),
    .Z(bus.Z),
    .N(bus.N),
    .P(bus.P)
  );

endmodule

// File: tb/tb_somador_acumulador.sv
// Scoreboard bench for somador_acumulador (WIDTH=8); honours SOMADOR_SATURATE_EN like the RTL.
module tb_somador_acumulador;
  import somador_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef struct {
    int s;
    int v;
    int vs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   m_s, m_v, m_vs;
  logic acc_seen;
  exp_t q[$];

  somador_acumulador_if #(.WIDTH(W)) bus ();

  somador_acumulador #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: full-precision integer arithmetic, then range check.
  task automatic model_op(input op_t o, input int b);
    int full;
    case (o)
      OP_LOAD: begin m_s = b; m_v = 0; end
      OP_CLR:  begin m_s = 0; m_v = 0; m_vs = 0; end
      default: begin
        full = (o == OP_ADD) ? (m_s + b) : (m_s - b);
        m_v = (full > MAXV || full < MINV) ? 1 : 0;
        if (m_v == 1) m_vs = 1;
`ifdef SOMADOR_SATURATE_EN
        if (full > MAXV) full = MAXV;
        if (full < MINV) full = MINV;
`else
        if (full > MAXV) full = full - (1 << W);
        if (full < MINV) full = full + (1 << W);
`endif
        m_s = full;
      end
    endcase
    q.push_back('{s: m_s, v: m_v, vs: m_vs});
  endtask

  task automatic drive(input logic r, input logic v, input op_t o, input int b);
    @(negedge clk);
    rst_n        = r;
    bus.in_valid = v;
    bus.op       = o;
    bus.B        = b[W-1:0];
    if (!r) begin
      m_s = 0; m_v = 0; m_vs = 0;
    end else if (v) begin
      model_op(o, b);
    end
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    acc_seen = rst_n && bus.in_valid;
    #1;
    chk("out_valid", int'(bus.out_valid), int'(acc_seen));
    if (bus.out_valid) begin
      chk("q_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_S", int'($signed(bus.S)), e.s);
        chk("sb_V", int'(bus.V), e.v);
        chk("sb_Vs", int'(bus.V_sticky), e.vs);
      end
    end
    chk("S", int'($signed(bus.S)), m_s);
    chk("Z", int'(bus.Z), (m_s == 0) ? 1 : 0);
    chk("N", int'(bus.N), (m_s < 0) ? 1 : 0);
    chk("P", int'(bus.P), (m_s % 2 == 0) ? 1 : 0);
    chk("V", int'(bus.V), m_v);
    chk("Vs", int'(bus.V_sticky), m_vs);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", n_total);
    $fatal(1, "timeout");
  end

  initial begin
    n_total = 0; n_bad = 0;
    m_s = 0; m_v = 0; m_vs = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = OP_LOAD;
    bus.B = '0;

    drive(1'b0, 1'b1, OP_ADD, 5);
    drive(1'b0, 1'b1, OP_ADD, 5);
    #2;
    chk("rst_S", int'($signed(bus.S)), 0);
    chk("rst_Z", int'(bus.Z), 1);
    chk("rst_ov", int'(bus.out_valid), 0);
    drive(1'b1, 1'b0, OP_LOAD, 0);

    drive(1'b1, 1'b1, OP_LOAD, 100);
    #2 chk("load100", int'($signed(bus.S)), 100);
    drive(1'b1, 1'b1, OP_ADD, 27);
    #2 chk("add27", int'($signed(bus.S)), 127);
    drive(1'b1, 1'b1, OP_ADD, 1);
`ifdef SOMADOR_SATURATE_EN
    #2 chk("ovf_pos_S", int'($signed(bus.S)), 127);
`else
    #2 chk("ovf_pos_S", int'($signed(bus.S)), -128);
`endif
    chk("ovf_pos_V", int'(bus.V), 1);
    drive(1'b1, 1'b1, OP_ADD, 0);
    #2 chk("add0_Vs", int'(bus.V_sticky), 1);
    drive(1'b1, 1'b1, OP_CLR, 0);
    #2 chk("clr_Vs", int'(bus.V_sticky), 0);
    drive(1'b1, 1'b1, OP_SUB, -128);
`ifdef SOMADOR_SATURATE_EN
    #2 chk("sub_min_S", int'($signed(bus.S)), 127);
`else
    #2 chk("sub_min_S", int'($signed(bus.S)), -128);
`endif
    chk("sub_min_V", int'(bus.V), 1);
    drive(1'b1, 1'b1, OP_LOAD, -1);
    drive(1'b1, 1'b1, OP_SUB, -128);
    #2 chk("m1_sub_min_S", int'($signed(bus.S)), 127);
    chk("m1_sub_min_V", int'(bus.V), 0);

    drive(1'b1, 1'b1, OP_LOAD, -6);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, OP_ADD, 9);
    #2 chk("hold_S", int'($signed(bus.S)), -6);

    drive(1'b0, 1'b1, OP_LOAD, 42);
    #2 chk("rst_wins_ov", int'(bus.out_valid), 0);
    drive(1'b1, 1'b0, OP_LOAD, 0);

    for (int i = 0; i < 60; i++) begin
      int bv;
      bv = $urandom_range(0, (1 << W) - 1) - (1 << (W - 1));
      if (i % 7 == 3) bv = MINV;
      if (i % 11 == 5) bv = MAXV;
      drive(1'b1, logic'($urandom_range(0, 3) != 0), op_t'($urandom_range(0, 3)), bv);
    end
    drive(1'b1, 1'b0, OP_LOAD, 0);
    drive(1'b1, 1'b0, OP_LOAD, 0);
    #2 chk("q_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
